// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: prefix bytes, arrow codes,
// FSM state encoding and the frame parity helper.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;

  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // PS/2 uses odd parity across the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Scan-code report bus from the PS/2 receiver to the key-control block.
interface ps2_keyboard_rx_if;

  logic [7:0] keyboardCode;
  logic       ps2_ready;
  logic       ps2_extended;
  logic       ps2_release;
  logic       ps2_err;

  modport master (
    output keyboardCode,
    output ps2_ready,
    output ps2_extended,
    output ps2_release,
    output ps2_err
  );

  modport slave (
    input keyboardCode,
    input ps2_ready,
    input ps2_extended,
    input ps2_release,
    input ps2_err
  );

endinterface

// File: rtl/ps2_sync_filter.sv
// Synchronises the raw PS/2 lines, glitch-filters ps2_clk and flags the
// filtered falling edge together with the synchronised data sample.
module ps2_sync_filter #(
  parameter int FILTER = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_fall,
  output logic o_data
);

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic          r_clk_meta;
  logic          r_clk_sync;
  logic          r_data_meta;
  logic          r_data_sync;
  logic          r_clk_filt;
  logic [CW-1:0] r_cnt;
  logic          w_settled;

  // The line is accepted at its new level on the FILTER-th differing sample.
  assign w_settled = (r_clk_sync != r_clk_filt) && (r_cnt == CW'(FILTER - 1));
  assign o_fall    = w_settled && r_clk_filt;
  assign o_data    = r_data_sync;

  // Idle PS/2 lines are high, so resetting to 1 avoids a spurious edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
      r_clk_filt  <= 1'b1;
      r_cnt       <= '0;
    end else begin
      r_clk_meta  <= i_ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_data_meta <= i_ps2_data;
      r_data_sync <= r_data_meta;
      if (r_clk_sync == r_clk_filt) begin
        r_cnt <= '0;
      end else if (w_settled) begin
        r_clk_filt <= r_clk_sync;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, folds E0/F0 prefixes
// into flags and reports one scan code per ready pulse.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER       = 4,
  parameter int TIMEOUT      = 50000,
  parameter int REPORT_BREAK = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  ps2_keyboard_rx_if.master     kb
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          w_fall;
  logic          w_data;

  logic [1:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic          r_ext;
  logic          r_brk;
  logic [7:0]    r_code;
  logic          r_ready;
  logic          r_extended;
  logic          r_release;
  logic          r_err;

  ps2_sync_filter #(
    .FILTER (FILTER)
  ) u_sync_filter (
    .clk        (clk),
    .rst        (rst),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .o_fall     (w_fall),
    .o_data     (w_data)
  );

  assign kb.keyboardCode = r_code;
  assign kb.ps2_ready    = r_ready;
  assign kb.ps2_extended = r_extended;
  assign kb.ps2_release  = r_release;
  assign kb.ps2_err      = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_to_cnt   <= '0;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_code     <= '0;
      r_ready    <= 1'b0;
      r_extended <= 1'b0;
      r_release  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_to_cnt <= '0;
        // A high start bit is ignored silently; wait for the next edge.
        if (w_fall && !w_data) begin
          r_state   <= ST_DATA;
          r_bit_cnt <= '0;
        end
      end else if (w_fall) begin
        // An edge takes priority over a timeout expiring in the same cycle.
        r_to_cnt <= '0;
        case (r_state)
          ST_DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            r_parity <= w_data;
            r_state  <= ST_STOP;
          end
          default: begin
            r_state <= ST_IDLE;
            if (odd_parity_ok(r_shift, r_parity) && w_data) begin
              if (r_shift == PS2_EXT) begin
                r_ext <= 1'b1;
              end else if (r_shift == PS2_BRK) begin
                r_brk <= 1'b1;
              end else begin
                if (!r_brk || (REPORT_BREAK != 0)) begin
                  r_code     <= r_shift;
                  r_extended <= r_ext;
                  r_release  <= r_brk;
                  r_ready    <= 1'b1;
                end
                r_ext <= 1'b0;
                r_brk <= 1'b0;
              end
            end else begin
              r_err <= 1'b1;
              r_ext <= 1'b0;
              r_brk <= 1'b0;
            end
          end
        endcase
      end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
        r_state  <= ST_IDLE;
        r_to_cnt <= '0;
        r_ext    <= 1'b0;
        r_brk    <= 1'b0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench: two receivers (break codes silent / reported) share one
// PS/2 stimulus stream; pulses are counted per clock and checked per frame.
module tb_ps2_keyboard_rx;

  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int rdy0 = 0, rdy1 = 0, err0 = 0, err1 = 0;
  int b_rdy0, b_rdy1, b_err0, b_err1;

  ps2_keyboard_rx_if kb0();
  ps2_keyboard_rx_if kb1();

  ps2_keyboard_rx #(.FILTER(2), .TIMEOUT(200), .REPORT_BREAK(0)) dut0 (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .kb(kb0)
  );

  ps2_keyboard_rx #(.FILTER(2), .TIMEOUT(200), .REPORT_BREAK(1)) dut1 (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .kb(kb1)
  );

  always #5 clk = ~clk;

  // A pulse held longer than one cycle inflates the count and is caught.
  always @(posedge clk) begin
    if (kb0.ps2_ready) rdy0 <= rdy0 + 1;
    if (kb1.ps2_ready) rdy1 <= rdy1 + 1;
    if (kb0.ps2_err)   err0 <= err0 + 1;
    if (kb1.ps2_err)   err1 <= err1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_rdy0 = rdy0; b_rdy1 = rdy1; b_err0 = err0; b_err1 = err1;
  endtask

  // Sends the first nbits bits of a frame; glitch_bit inserts a 1-clk low
  // pulse on ps2_clk during that bit's high phase.
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int nbits, input int glitch_bit);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      for (int c = 0; c < HALF; c++) begin
        @(negedge clk);
        if (i == glitch_bit && c == 5) ps2_clk = 1'b0;
        if (i == glitch_bit && c == 6) ps2_clk = 1'b1;
      end
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    if (nbits == 11) begin
      repeat (30) @(negedge clk);
      $display("frame %02h bad_par=%0d: code0=%02h ext0=%0d code1=%02h ext1=%0d rel1=%0d rdy0=%0d rdy1=%0d err0=%0d",
               b, bad_par, kb0.keyboardCode, kb0.ps2_extended, kb1.keyboardCode,
               kb1.ps2_extended, kb1.ps2_release, rdy0, rdy1, err0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_code", {24'd0, kb0.keyboardCode}, 32'h00);
    check("rst_ready", {31'd0, kb0.ps2_ready}, 32'd0);
    check("rst_err", {31'd0, kb0.ps2_err}, 32'd0);
    check("rst_ext_rel", {30'd0, kb0.ps2_extended, kb0.ps2_release}, 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // 1: extended left arrow
    snap();
    send_frame(8'hE0, 0, 11, -1);
    check("t1_e0_nopulse", rdy0 - b_rdy0, 0);
    send_frame(8'h6B, 0, 11, -1);
    check("t1_ready", rdy0 - b_rdy0, 1);
    check("t1_code", {24'd0, kb0.keyboardCode}, 32'h6B);
    check("t1_ext", {31'd0, kb0.ps2_extended}, 1);
    check("t1_rel", {31'd0, kb0.ps2_release}, 0);
    check("t1_err", err0 - b_err0, 0);

    // 2: extended break of right arrow, then plain up arrow
    snap();
    send_frame(8'hE0, 0, 11, -1);
    send_frame(8'hF0, 0, 11, -1);
    send_frame(8'h74, 0, 11, -1);
    check("t2_silent_ready", rdy0 - b_rdy0, 0);
    check("t2_silent_code", {24'd0, kb0.keyboardCode}, 32'h6B);
    check("t2_rep_ready", rdy1 - b_rdy1, 1);
    check("t2_rep_code", {24'd0, kb1.keyboardCode}, 32'h74);
    check("t2_rep_ext", {31'd0, kb1.ps2_extended}, 1);
    check("t2_rep_rel", {31'd0, kb1.ps2_release}, 1);
    snap();
    send_frame(8'h75, 0, 11, -1);
    check("t2_next_ready", rdy0 - b_rdy0, 1);
    check("t2_next_code", {24'd0, kb0.keyboardCode}, 32'h75);
    check("t2_next_ext", {31'd0, kb0.ps2_extended}, 0);
    check("t2_rep_next_rel", {31'd0, kb1.ps2_release}, 0);

    // 3: parity error then good frame
    snap();
    send_frame(8'h72, 1, 11, -1);
    check("t3_err", err0 - b_err0, 1);
    check("t3_err_noready", rdy0 - b_rdy0, 0);
    snap();
    send_frame(8'h72, 0, 11, -1);
    check("t3_ready", rdy0 - b_rdy0, 1);
    check("t3_code", {24'd0, kb0.keyboardCode}, 32'h72);
    check("t3_good_noerr", err0 - b_err0, 0);

    // 4: truncated frame aborted by timeout
    snap();
    send_frame(8'h55, 0, 6, -1);
    repeat (250) @(negedge clk);
    check("t4_noerr", err0 - b_err0, 0);
    check("t4_noready", rdy0 - b_rdy0, 0);
    send_frame(8'h6B, 0, 11, -1);
    check("t4_ready", rdy0 - b_rdy0, 1);
    check("t4_code", {24'd0, kb0.keyboardCode}, 32'h6B);
    check("t4_err_after", err0 - b_err0, 0);

    // 5: asynchronous reset during the 4th data bit
    send_frame(8'h74, 0, 4, -1);
    ps2_data = 1'b0;
    repeat (10) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("t5_code0", {24'd0, kb0.keyboardCode}, 32'h00);
    check("t5_ext0", {31'd0, kb0.ps2_extended}, 0);
    check("t5_code1", {24'd0, kb1.keyboardCode}, 32'h00);
    check("t5_flags1", {29'd0, kb1.ps2_ready, kb1.ps2_release, kb1.ps2_err}, 0);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    snap();
    send_frame(8'h74, 0, 11, -1);
    check("t5_ready", rdy0 - b_rdy0, 1);
    check("t5_code", {24'd0, kb0.keyboardCode}, 32'h74);

    // 6: single-clock glitches in idle and mid-frame are rejected
    snap();
    @(negedge clk) ps2_clk = 1'b0;
    @(negedge clk) ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h75, 0, 11, 3);
    check("t6_ready", rdy0 - b_rdy0, 1);
    check("t6_code", {24'd0, kb0.keyboardCode}, 32'h75);
    check("t6_noerr", err0 - b_err0, 0);
    check("t6_noerr1", err1 - b_err1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
PS/2 keyboard receiver. It is the stage directly upstream of the Pac-Man key-control block and drives that block's keyboardCode and ps2_ready inputs. The block synchronises and filters the raw PS/2 clock/data lines and deserialises 11-bit frames. It interprets the E0 (extended) and F0 (break) prefixes and emits one ready pulse per completed scan code.

Parameters:
FILTER, 4, consecutive identical clk samples required before a filtered ps2_clk level change is accepted (glitch reject).
TIMEOUT, 50000, clk cycles without a filtered ps2_clk falling edge mid-frame before the frame is aborted (0.5 ms at 100 MHz).
REPORT_BREAK, 0, 1 = break codes also pulse ps2_ready with ps2_release=1; 0 = break codes are silently consumed.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ps2_clk  in  1  raw PS/2 clock line, asynchronous
ps2_data  in  1  raw PS/2 data line, asynchronous
keyboardCode  out  8  last reported scan code (without prefixes)
ps2_ready  out  1  one-cycle pulse: keyboardCode/flags just updated
ps2_extended  out  1  reported code was preceded by E0
ps2_release  out  1  reported code was preceded by F0 (only if REPORT_BREAK=1)
ps2_err  out  1  one-cycle pulse on parity or stop-bit error

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM to IDLE, shift register, bit count, timeout counter and prefix flags cleared. Reset asserted mid-frame discards the partial frame.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- The filtered ps2_clk level changes only after FILTER equal consecutive synchronised samples.
- A falling edge is a filtered 1->0 transition. ps2_data is sampled (synchronised) in the same cycle as the edge.
- FSM states, advancing one state or bit per falling edge:
  - IDLE: sampled data=0 -> DATA with bit count 0. Sampled data=1 is treated as an invalid start bit: stay in IDLE, no error flagged.
  - DATA: shift in LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: validate, then -> IDLE.
- Validation in STOP requires both odd parity (XOR of 8 data bits and the parity bit = 1) and stop bit = 1.
  - Failure: ps2_err pulses 1 cycle, byte discarded, both prefix flags cleared.
- Valid byte handling:
  - E0: set ext_pending; no pulse.
  - F0: set brk_pending; no pulse.
  - Any other byte, brk_pending=0: keyboardCode<=byte, ps2_extended<=ext_pending, ps2_release<=0, ps2_ready pulses 1 cycle.
  - Any other byte, brk_pending=1 and REPORT_BREAK=1: same update with ps2_release<=1.
  - Any other byte, brk_pending=1 and REPORT_BREAK=0: outputs untouched, no pulse.
  - In all non-prefix cases both pending flags clear afterwards.
- Latency: ps2_ready/ps2_err are asserted in the clk cycle after the filtered falling edge that samples the stop bit.
- keyboardCode, ps2_extended and ps2_release hold until the next report.
- Timeout: in any state other than IDLE the counter increments each clk and resets on every falling edge.
  - When it reaches TIMEOUT-1: FSM to IDLE, partial frame discarded, prefix flags cleared, no ps2_err.
  - The counter is held at 0 in IDLE.
- The block is receive-only: it never drives ps2_clk/ps2_data (no host-to-device inhibit).
- Simultaneous events: a falling edge in the same cycle as the timeout expiry is processed as a frame bit, and the timeout does not fire.

Decomposition:
- Shared package ps2_pkg:
  - prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - arrow codes KEY_LEFT=8'h6B, KEY_RIGHT=8'h74, KEY_UP=8'h75, KEY_DOWN=8'h72 (already consumed downstream);
  - FSM state encoding IDLE/DATA/PARITY/STOP.
- Sub-module ps2_sync_filter: 2-flop synchroniser, FILTER-sample glitch filter and falling-edge pulse for ps2_clk, plus synchronised ps2_data output.

Test Plan:
- Bench parameters: FILTER=2, TIMEOUT=200, PS/2 bit half-period 20 clk.
1. Frames E0, 6B -> exactly one ps2_ready pulse, keyboardCode=8'h6B, ps2_extended=1, ps2_release=0, ps2_err stays 0.
2. Frames E0, F0, 74 with REPORT_BREAK=0 -> no ps2_ready, keyboardCode keeps prior 8'h6B.
   - Next frame 75 -> keyboardCode=8'h75, ps2_extended=0 (prefixes cleared).
   - Repeat with REPORT_BREAK=1 -> pulse with keyboardCode=8'h74, ps2_extended=1, ps2_release=1.
3. Frame 72 with parity bit inverted -> one ps2_err pulse, no ps2_ready. Following good frame 72 -> ps2_ready, keyboardCode=8'h72.
4. Start bit plus 5 data bits, then lines idle for 250 clk -> FSM back to IDLE with no ps2_err. Following full frame 6B decodes correctly.
5. Pull rst low during the 4th data bit -> all outputs 0 immediately (asynchronous). After release, frame 74 -> keyboardCode=8'h74, ps2_ready pulse.
6. 1-clk low glitch on ps2_clk during IDLE and again mid-frame -> no bit sampled. Frame 75 still decodes to 8'h75 with no ps2_err.
